// File: rtl/pwm_tone_generator.sv
// pwm_tone_generator
//   Phase-accumulator (NCO) tone source driving a single-bit PWM audio pin.
//   The phase delta and carrier top come from the note sequencer. The duty
//   cycle is latched only at carrier wraps, so a period is never cut short
//   or stretched by a mid-period sample change.
//   Optional build macro PWM_TONE_ENVELOPE_EN adds an attack-ramp gain stage
//   (ENV_STEP carrier periods per gain step) between waveform and PWM.
module pwm_tone_generator #(
   parameter int unsigned WAVE = 1      // 0 = square, 1 = sawtooth, 2 = triangle
`ifdef PWM_TONE_ENVELOPE_EN
   ,
   parameter int unsigned ENV_STEP = 64 // carrier periods per gain increment
`endif
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_top,
   input  logic        i_top_valid,
   input  logic [31:0] i_phase_delta,
   output logic        o_pwm,
   output logic [7:0]  o_sample,
   output logic        o_period_start
);

   logic [31:0] r_phase;
   logic [7:0]  r_count;
   logic [7:0]  r_top;
   logic [7:0]  r_top_pending;
   logic [7:0]  r_duty;

   logic [7:0]  wave_sample;   // raw waveform, zero while resting
   logic [7:0]  sample;        // value fed to o_sample and the duty computation
   logic [16:0] duty_prod;
   logic [7:0]  duty_next;
   logic        wrap;

   // Waveform shaping from the top bits of the phase accumulator
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wave_sample = 8'h00;
      if (i_phase_delta != 32'd0) begin
         case (WAVE)
            0:       wave_sample = r_phase[31] ? 8'hff : 8'h00;
            2:       wave_sample = r_phase[31] ? ~r_phase[30:23] : r_phase[30:23];
            default: wave_sample = r_phase[31:24];
         endcase
      end
   end

`ifdef PWM_TONE_ENVELOPE_EN
   localparam logic [15:0] ENV_LAST = 16'(ENV_STEP - 1);

   logic [7:0]  r_gain;
   logic [15:0] r_env_count;
   logic [31:0] r_prev_delta;
   logic [15:0] gain_prod;

   // Scale the raw waveform by the envelope gain
   always_comb begin
      gain_prod = {8'h00, wave_sample} * {8'h00, r_gain};
      sample    = 8'(gain_prod >> 8);
   end

   // Attack ramp: gain restarts on every note change and climbs once per ENV_STEP periods
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_gain       <= 8'h00;
         r_env_count  <= 16'h0000;
         r_prev_delta <= 32'h0000_0000;
      end else begin
         r_prev_delta <= i_phase_delta;
         if (i_phase_delta != r_prev_delta) begin
            r_gain      <= 8'h00;
            r_env_count <= 16'h0000;
         end else if (wrap) begin
            if (r_env_count >= ENV_LAST) begin
               r_env_count <= 16'h0000;
               if (r_gain != 8'hff) begin
                  r_gain <= r_gain + 8'd1;
               end
            end else begin
               r_env_count <= r_env_count + 16'd1;
            end
         end
      end
   end
`else
   // No envelope: the raw waveform goes straight to the PWM stage
   always_comb begin
      sample = wave_sample;
   end
`endif

   // Duty for the next carrier period, scaled to the period length it will run in
   always_comb begin
      wrap      = (r_count == r_top);
      duty_prod = {9'd0, sample} * ({9'd0, r_top_pending} + 17'd1);
      duty_next = 8'(duty_prod >> 8);
   end

   // NCO, carrier counter, period-boundary duty/top latching and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_phase        <= 32'h0000_0000;
         r_count        <= 8'h00;
         r_top          <= 8'hff;
         r_top_pending  <= 8'hff;
         r_duty         <= 8'h00;
         o_pwm          <= 1'b0;
         o_sample       <= 8'h00;
         o_period_start <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register sees pre-edge values of the others.
         if (i_phase_delta == 32'd0) begin
            r_phase <= 32'h0000_0000;
         end else begin
            r_phase <= r_phase + i_phase_delta;
         end

         o_sample <= sample;

         // A top written on a wrap cycle lands in pending after r_top has loaded,
         // so it takes effect one wrap later.
         if (i_top_valid) begin
            r_top_pending <= i_top;
         end

         if (wrap) begin
            r_count        <= 8'h00;
            r_top          <= r_top_pending;
            r_duty         <= duty_next;
            o_period_start <= 1'b1;
         end else begin
            r_count        <= r_count + 8'd1;
            o_period_start <= 1'b0;
         end

         o_pwm <= (r_count < r_duty);
      end
   end

endmodule

// File: tb/tb_pwm_tone_generator.sv
// Self-checking bench for pwm_tone_generator: three instances (square,
// sawtooth, triangle) share one stimulus stream and are compared every cycle
// against an arithmetic reference model, with hand-computed spot checks.
module tb_pwm_tone_generator;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  top;
   logic        top_valid;
   logic [31:0] delta;

   logic        pwm0, pwm1, pwm2;
   logic [7:0]  samp0, samp1, samp2;
   logic        pstart0, pstart1, pstart2;

   pwm_tone_generator #(.WAVE(0)) u_sq (
      .i_clk(clk), .i_reset(rst), .i_top(top), .i_top_valid(top_valid),
      .i_phase_delta(delta), .o_pwm(pwm0), .o_sample(samp0), .o_period_start(pstart0));

   pwm_tone_generator #(.WAVE(1)) u_saw (
      .i_clk(clk), .i_reset(rst), .i_top(top), .i_top_valid(top_valid),
      .i_phase_delta(delta), .o_pwm(pwm1), .o_sample(samp1), .o_period_start(pstart1));

   pwm_tone_generator #(.WAVE(2)) u_tri (
      .i_clk(clk), .i_reset(rst), .i_top(top), .i_top_valid(top_valid),
      .i_phase_delta(delta), .o_pwm(pwm2), .o_sample(samp2), .o_period_start(pstart2));

   always #20 clk = ~clk;   // 25 MHz

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_start = 0;
   int last_len   = 0;

   // Reference model state
   logic [31:0] m_phase;
   int m_count, m_top, m_pend, m_start;
   int m_duty [3];
   int m_pwm [3];
   int m_sample [3];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // Waveform value as a function of phase, from the shape definitions
   function automatic int wave_of(input int w, input logic [31:0] ph, input logic [31:0] d);
      longint p;
      p = ph;
      if (d == 0) return 0;
      if (w == 0) return (p >= 64'h8000_0000) ? 255 : 0;
      if (w == 1) return int'(p / 64'h0100_0000);
      if (p < 64'h8000_0000) return int'(p / 64'h0080_0000);
      return 255 - int'((p - 64'h8000_0000) / 64'h0080_0000);
   endfunction

   // Advance the model by one clock using the inputs present at that edge
   task automatic model_step();
      int s [3];
      if (rst) begin
         m_phase = 32'd0;
         m_count = 0;
         m_top   = 255;
         m_pend  = 255;
         m_start = 0;
         for (int w = 0; w < 3; w++) begin
            m_duty[w] = 0;
            m_pwm[w] = 0;
            m_sample[w] = 0;
         end
         return;
      end
      for (int w = 0; w < 3; w++) begin
         s[w] = wave_of(w, m_phase, delta);
         m_pwm[w] = (m_count < m_duty[w]) ? 1 : 0;
      end
      if (m_count == m_top) begin
         for (int w = 0; w < 3; w++) m_duty[w] = (s[w] * (m_pend + 1)) / 256;
         m_count = 0;
         m_top   = m_pend;
         m_start = 1;
      end else begin
         m_count++;
         m_start = 0;
      end
      for (int w = 0; w < 3; w++) m_sample[w] = s[w];
      if (top_valid) m_pend = top;
      m_phase = (delta == 32'd0) ? 32'd0 : m_phase + delta;
   endtask

   // One clock: edge, model update, full output comparison, period bookkeeping
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      check("pwm_sq",    pwm0,    m_pwm[0]);
      check("pwm_saw",   pwm1,    m_pwm[1]);
      check("pwm_tri",   pwm2,    m_pwm[2]);
      check("samp_sq",   samp0,   m_sample[0]);
      check("samp_saw",  samp1,   m_sample[1]);
      check("samp_tri",  samp2,   m_sample[2]);
      check("start_sq",  pstart0, m_start);
      check("start_saw", pstart1, m_start);
      check("start_tri", pstart2, m_start);
      if (rst) begin
         last_start = cyc;
      end else if (pstart1) begin
         last_len   = cyc - last_start;
         last_start = cyc;
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic write_top(input logic [7:0] t);
      top = t;
      top_valid = 1'b1;
      tick();
      top_valid = 1'b0;
   endtask

   initial begin
      int hi;
      rst = 1'b1; delta = 32'd0; top = 8'd0; top_valid = 1'b0;
      run(3);
      rst = 1'b0;

      // Idle after reset: silent, carrier keeps 256-cycle periods
      check("rst_sample", samp1, 0);
      check("rst_pwm", pwm1, 0);
      check("rst_start", pstart1, 0);
      run(256);
      check("idle_start", pstart1, 1);
      check("idle_period1", last_len, 256);
      run(256);
      check("idle_period2", last_len, 256);

      // Sawtooth ramp, one LSB per clock
      delta = 32'h0100_0000;
      pulse_reset();
      tick(); check("saw_e1", samp1, 0);
      tick(); check("saw_e2", samp1, 1);
      run(8); check("saw_e10", samp1, 9);
      run(246);
      check("saw_wrap_start", pstart1, 1);
      check("saw_wrap_sample", samp1, 255);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         if (i == 0) check("saw_roll_to_zero", samp1, 0);
         hi += int'(pwm1);
      end
      check("saw_high_time", hi, 255);

      // Square wave: 256 clocks low, 256 high; alternating full/empty periods
      delta = 32'h0080_0000;
      pulse_reset();
      run(256); check("sq_low_half", samp0, 0);
      tick();   check("sq_high_half", samp0, 255);
      run(255); check("sq_high_end", samp0, 255);
      check("sq_wrap_start", pstart0, 1);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         if (i == 0) check("sq_back_low", samp0, 0);
         hi += int'(pwm0);
      end
      check("sq_full_period", hi, 255);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         hi += int'(pwm0);
      end
      check("sq_empty_period", hi, 0);

      // Top change mid-period applies at the next wrap only
      delta = 32'h0100_0000;
      pulse_reset();
      run(50);
      write_top(8'd99);
      run(205);
      check("top_old_start", pstart1, 1);
      check("top_old_period", last_len, 256);
      run(100); check("top_new_period1", last_len, 100);
      run(100); check("top_new_period2", last_len, 100);

      // top=0: a wrap on every cycle, output held low
      write_top(8'd0);
      run(110);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("top0_start", pstart1, 1);
         check("top0_pwm", pwm1, 0);
      end

      // Top written on a wrap cycle is used one wrap later
      write_top(8'd7);
      tick(); check("wrap_write_still_old", pstart1, 1);
      tick(); check("wrap_write_counting", pstart1, 0);
      run(7);
      check("wrap_write_start", pstart1, 1);
      check("wrap_write_period", last_len, 8);

      // Rest clears the phase; nonzero-to-nonzero change keeps it continuous
      delta = 32'd0;
      run(5); check("rest_sample", samp1, 0);
      delta = 32'h0100_0000;
      tick(); check("restart_e1", samp1, 0);
      tick(); check("restart_e2", samp1, 1);
      tick(); check("restart_e3", samp1, 2);
      delta = 32'h0200_0000;
      tick(); check("continuous_e1", samp1, 3);
      tick(); check("continuous_e2", samp1, 5);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            case ($urandom_range(0, 3))
               0: delta = 32'd0;
               1: delta = $urandom;
               2: delta = 32'($urandom_range(1, 8)) << 22;
               default: delta = 32'($urandom_range(1, 1000));
            endcase
         end
         top_valid = ($urandom_range(0, 15) == 0);
         top = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
         rst = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 1'b0;
      top_valid = 1'b0;

      // Reset mid-period: first period afterwards runs with top=255
      delta = 32'h0100_0000;
      write_top(8'd99);
      run(150);
      run(37);
      pulse_reset();
      run(255);
      check("rst_mid_no_early_start", pstart1, 0);
      tick();
      check("rst_mid_start", pstart1, 1);
      check("rst_mid_period", last_len, 256);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
